// File: rtl/led_frame_sequencer.sv
// LED driver frame sequencer: shifts one frame out MSB first, latches it
// into one of four driver banks, and runs a free grayscale clock with blanking.
module led_frame_sequencer #(
    parameter int DATA_W    = 32,
    parameter int SCLK_DIV  = 2,
    parameter int LAT_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        chan,
    input  logic [DATA_W-1:0] data,
    input  logic              gs_en,
    input  logic [7:0]        gs_psc,
    output logic              ready,
    output logic              done,
    output logic              serial,
    output logic              sclk,
    output logic [3:0]        lat,
    output logic              gsclk,
    output logic              blank
);

    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int LAT_W = $clog2(LAT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [1:0]        r_chan;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [LAT_W-1:0]  r_lcnt;
    logic              r_sclk;
    logic [3:0]        r_lat;
    logic              r_done;

    logic [7:0]        r_psc;
    logic [7:0]        r_lim;
    logic [11:0]       r_gscnt;
    logic              r_gsclk;
    logic              r_blank;

    logic              w_half_end;
    logic              w_bit_end;

    assign w_half_end = (r_div == DIV_LAST);
    assign w_bit_end  = w_half_end && r_sclk;

    // Serial is the MSB of the shift register, so it only moves when the
    // register shifts, which happens solely as sclk returns low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_chan  <= 2'd0;
            r_div   <= '0;
            r_bit   <= '0;
            r_lcnt  <= '0;
            r_sclk  <= 1'b0;
            r_lat   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg <= data;
                        r_chan  <= chan;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_half_end) begin
                        r_div <= r_div + DIV_W'(1);
                    end else if (!r_sclk) begin
                        r_div  <= '0;
                        r_sclk <= 1'b1;
                    end else if (r_bit == BIT_LAST) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_lat   <= 4'b0001 << r_chan;
                        r_lcnt  <= '0;
                        r_state <= S_LATCH;
                    end else begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_bit   <= r_bit + BIT_W'(1);
                        r_shreg <= r_shreg << 1;
                    end
                end
                S_LATCH: begin
                    if (r_lcnt == LAT_LAST) begin
                        r_lat   <= 4'd0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt + LAT_W'(1);
                    end
                end
                default: begin
                    r_lat   <= 4'd0;
                    r_sclk  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The half-period limit is re-sampled only at a toggle, so a prescaler
    // change never cuts short the half-period already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc   <= 8'd0;
            r_lim   <= 8'd0;
            r_gscnt <= 12'd0;
            r_gsclk <= 1'b0;
            r_blank <= 1'b0;
        end else if (!gs_en) begin
            r_psc   <= 8'd0;
            r_lim   <= gs_psc;
            r_gscnt <= 12'd0;
            r_gsclk <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_blank <= 1'b0;
            if (r_psc == r_lim) begin
                r_psc   <= 8'd0;
                r_lim   <= gs_psc;
                r_gsclk <= ~r_gsclk;
                if (!r_gsclk) begin
                    r_gscnt <= r_gscnt + 12'd1;
                    r_blank <= (r_gscnt == 12'hFFF);
                end
            end else begin
                r_psc <= r_psc + 8'd1;
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = r_done;
    assign serial = r_shreg[DATA_W-1];
    assign sclk   = r_sclk;
    assign lat    = r_lat;
    assign gsclk  = r_gsclk;
    assign blank  = r_blank;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: frame vectors from a table plus
// hand-written reset, back-to-back and grayscale sequences.
module tb_led_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] chan = 2'd0;
    logic [7:0] data = 8'd0;
    logic       gs_en = 1'b0;
    logic [7:0] gs_psc = 8'd0;
    logic       ready, done, serial, sclk, gsclk, blank;
    logic [3:0] lat;

    int errors = 0;
    int checks = 0;

    led_frame_sequencer #(
        .DATA_W(8),
        .SCLK_DIV(1),
        .LAT_TICKS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .chan(chan),
        .data(data),
        .gs_en(gs_en),
        .gs_psc(gs_psc),
        .ready(ready),
        .done(done),
        .serial(serial),
        .sclk(sclk),
        .lat(lat),
        .gsclk(gsclk),
        .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        logic [7:0] bits;
        logic [3:0] lat;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at the first falling edge after the start was captured.
    task automatic watch(input logic [7:0] eb, input logic [3:0] el,
                         input string tag);
        logic [7:0] got;
        int nb, nlat, nbad, nlow, ndone;
        bit fin;
        got = 8'd0; nb = 0; nlat = 0; nbad = 0; nlow = 0; ndone = 0;
        fin = 1'b0;
        for (int k = 0; k < 60 && !fin; k++) begin
            if (ready) begin
                fin = 1'b1;
            end else begin
                nlow++;
                if (done) ndone++;
                if (sclk) begin
                    got = {got[6:0], serial};
                    nb++;
                end
                if (lat == el) nlat++;
                else if (lat != 4'd0) nbad++;
                @(negedge clk);
            end
        end
        chk({tag, " finish"}, 32'(fin), 32'd1);
        chk({tag, " ready_low"}, nlow, 19);
        chk({tag, " bits"}, {nb[23:0], got}, {24'd8, eb});
        chk({tag, " lat_cycles"}, nlat, 3);
        chk({tag, " lat_other"}, nbad, 0);
        chk({tag, " done_end"}, {31'd0, done}, 32'd1);
        chk({tag, " done_early"}, ndone, 0);
        chk({tag, " lat_end"}, {28'd0, lat}, 32'd0);
    endtask

    task automatic frame(input logic [7:0] d, input logic [1:0] c,
                         input logic [7:0] eb, input logic [3:0] el,
                         input string tag);
        start = 1'b1;
        data = d;
        chan = c;
        @(negedge clk);
        start = 1'b0;
        watch(eb, el, tag);
    endtask

    task automatic rise(output int n);
        logic prev;
        prev = gsclk;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n++;
            if (gsclk && !prev) break;
            prev = gsclk;
        end
    endtask

    task automatic to_blank(output int n);
        n = 0;
        for (int k = 0; k < 9000; k++) begin
            @(negedge clk);
            n++;
            if (blank) break;
        end
    endtask

    function automatic logic [9:0] outs();
        return {ready, done, serial, sclk, lat, gsclk, blank};
    endfunction

    initial begin
        int n;
        vecs[0] = '{d: 8'hA5, c: 2'd2, bits: 8'b1010_0101, lat: 4'b0100};
        vecs[1] = '{d: 8'h3C, c: 2'd0, bits: 8'b0011_1100, lat: 4'b0001};
        vecs[2] = '{d: 8'h81, c: 2'd3, bits: 8'b1000_0001, lat: 4'b1000};
        vecs[3] = '{d: 8'h00, c: 2'd1, bits: 8'b0000_0000, lat: 4'b0010};

        #1 rst_n = 1'b0;
        #2 chk("reset_outs", 32'(outs()), 32'h200);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Consecutive frames start on the done cycle of the previous one.
        for (int i = 0; i < 4; i++)
            frame(vecs[i].d, vecs[i].c, vecs[i].bits, vecs[i].lat,
                  $sformatf("vec%0d", i));

        // Start held through a whole frame with new payload.
        @(negedge clk);
        start = 1'b1;
        data = 8'hA5;
        chan = 2'd2;
        @(negedge clk);
        data = 8'hFF;
        chan = 2'd1;
        watch(8'hA5, 4'b0100, "b2b_first");
        @(negedge clk);
        start = 1'b0;
        watch(8'hFF, 4'b0010, "b2b_second");

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        start = 1'b1;
        data = 8'hFF;
        chan = 2'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_shift", {30'd0, sclk, serial}, 32'd3);
        #2 rst_n = 1'b0;
        #1 chk("rst_shift_outs", 32'(outs()), 32'h200);
        @(negedge clk);
        chk("rst_shift_nodone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        frame(8'h5A, 2'd1, 8'b0101_1010, 4'b0010, "after_rst1");

        // Asynchronous reset in the middle of LATCH.
        @(negedge clk);
        start = 1'b1;
        data = 8'h0F;
        chan = 2'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_latch", {28'd0, lat}, 32'h8);
        #2 rst_n = 1'b0;
        #1 chk("rst_latch_outs", 32'(outs()), 32'h200);
        @(negedge clk);
        rst_n = 1'b1;
        frame(8'hC3, 2'd2, 8'b1100_0011, 4'b0100, "after_rst2");

        // Grayscale: first blank, blank interval, period.
        @(negedge clk);
        gs_psc = 8'd0;
        gs_en = 1'b1;
        to_blank(n);
        chk("gs_first_blank", n, 8191);
        to_blank(n);
        chk("gs_blank_interval", n, 8192);
        rise(n);
        rise(n);
        chk("gs_period_psc0", n, 2);

        frame(8'hA5, 2'd0, 8'b1010_0101, 4'b0001, "frame_gs");
        rise(n);
        rise(n);
        chk("gs_period_after_frame", n, 2);

        gs_psc = 8'd3;
        rise(n);
        rise(n);
        rise(n);
        chk("gs_period_psc3", n, 8);

        // Prescaler change right after a rise: current half keeps old length.
        gs_psc = 8'd0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n++;
            if (!gsclk) break;
        end
        chk("gs_psc_hold_half", n, 4);
        rise(n);
        chk("gs_psc_new_half", n, 1);

        // Disable mid-period, then re-enable.
        repeat (300) @(negedge clk);
        rise(n);
        gs_en = 1'b0;
        @(negedge clk);
        chk("gs_disable", {30'd0, gsclk, blank}, 32'd0);
        @(negedge clk);
        gs_en = 1'b1;
        to_blank(n);
        chk("gs_reenable_blank", n, 8191);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
